memtrace_lane_issuer: RTL and testbench

//  Consumer end of the memtrace read interface: accepts one trace bundle (NUM_THREADS x 64-bit

---
 rtl/memtrace_pkg.sv | 8 +
 rtl/memtrace_lane_issuer_if.sv | 25 ++
 rtl/memtrace_lane_pick.sv | 15 +
 rtl/memtrace_lane_issuer.sv | 86 ++++++++
 tb/tb_memtrace_lane_issuer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/memtrace_pkg.sv
// memtrace_pkg: shared data width, issuer states and lane-index width helper
package memtrace_pkg;
    localparam int DATA_WIDTH = 64;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;
    function automatic int tid_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/memtrace_lane_issuer_if.sv
// memtrace_lane_issuer_if: trace-read, memory-request and response signals between source and issuer
interface memtrace_lane_issuer_if
    import memtrace_pkg::*;
#(
    parameter int NUM_THREADS = 4
) ();
    localparam int TID_W = tid_width(NUM_THREADS);
    logic                              trace_read_valid;
    logic                              trace_read_ready;
    logic [DATA_WIDTH*NUM_THREADS-1:0] trace_read_address;
    logic                              trace_read_finished;
    logic                              req_valid;
    logic                              req_ready;
    logic [DATA_WIDTH-1:0]             req_addr;
    logic [TID_W-1:0]                  req_tid;
    logic                              resp_valid;
    modport master (
        output trace_read_valid, trace_read_address, trace_read_finished, req_ready, resp_valid,
        input  trace_read_ready, req_valid, req_addr, req_tid
    );
    modport slave (
        input  trace_read_valid, trace_read_address, trace_read_finished, req_ready, resp_valid,
        output trace_read_ready, req_valid, req_addr, req_tid
    );
endinterface

// File: rtl/memtrace_lane_pick.sv
// memtrace_lane_pick: lowest-set-bit priority encoder over the pending lane mask
module memtrace_lane_pick #(
    parameter int NUM_THREADS = 4,
    parameter int TID_W       = 2
) (
    input  logic [NUM_THREADS-1:0] mask,
    output logic [TID_W-1:0]       tid,
    output logic                   lane_any
);
    always_comb begin
        tid = '0;
        for (int g = NUM_THREADS - 1; g >= 0; g--) tid = mask[g] ? TID_W'(g) : tid;
    end
    assign lane_any = |mask;
endmodule

// File: rtl/memtrace_lane_issuer.sv
// memtrace_lane_issuer: serialises trace bundles into per-lane memory requests and tracks completion
module memtrace_lane_issuer
    import memtrace_pkg::*;
#(
    parameter int NUM_THREADS  = 4,
    parameter int MAX_INFLIGHT = 8,
    parameter int CNT_W        = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    memtrace_lane_issuer_if.slave      bus,
    output logic                       done,
    output logic                       error,
    output logic [CNT_W-1:0]           req_count
);
    localparam int TID_W = tid_width(NUM_THREADS);
    localparam int OUT_W = $clog2(MAX_INFLIGHT + 1);

    state_e                 state, state_nxt;
    logic [NUM_THREADS-1:0] mask, mask_nxt, lane_nz;
    logic [DATA_WIDTH-1:0]  addr_q [NUM_THREADS];
    logic [OUT_W-1:0]       outstanding, out_nxt;
    logic [TID_W-1:0]       tid;
    logic                   finished_seen, fin, hs, fire, resp_ok, lane_any;

    genvar g;
    generate
        for (g = 0; g < NUM_THREADS; g++) begin : g_nz
            assign lane_nz[g] = bus.trace_read_address[DATA_WIDTH*g +: DATA_WIDTH] != '0;
        end
    endgenerate

    memtrace_lane_pick #(.NUM_THREADS(NUM_THREADS), .TID_W(TID_W)) u_pick (
        .mask(mask),
        .tid(tid),
        .lane_any(lane_any)
    );

    // Combinational outputs are forced low while reset is held
    assign bus.trace_read_ready = !reset && state == IDLE;
    assign bus.req_valid        = !reset && state == ISSUE && lane_any && outstanding < OUT_W'(MAX_INFLIGHT);
    assign bus.req_addr         = bus.req_valid ? addr_q[tid] : '0;
    assign bus.req_tid          = bus.req_valid ? tid : '0;
    assign done                 = !reset && state == DONE;

    assign hs      = bus.trace_read_valid && bus.trace_read_ready;
    assign fire    = bus.req_valid && bus.req_ready;
    assign resp_ok = bus.resp_valid && outstanding != '0;
    assign fin     = finished_seen || bus.trace_read_finished;
    assign out_nxt = outstanding + OUT_W'(fire) - OUT_W'(resp_ok);
    assign mask_nxt = hs ? lane_nz : fire ? mask & ~(NUM_THREADS'(1) << tid) : mask;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (hs && |lane_nz) ? ISSUE : fin ? DRAIN : IDLE;
            ISSUE:   state_nxt = (fire && mask_nxt == '0) ? (fin ? DRAIN : IDLE) : ISSUE;
            DRAIN:   state_nxt = out_nxt == '0 ? DONE : DRAIN;
            default: state_nxt = DONE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            mask          <= '0;
            outstanding   <= '0;
            finished_seen <= 1'b0;
            error         <= 1'b0;
            req_count     <= '0;
        end else begin
            state         <= state_nxt;
            mask          <= mask_nxt;
            outstanding   <= out_nxt;
            finished_seen <= fin;
            error         <= error || (bus.resp_valid && outstanding == '0);
            req_count     <= req_count + CNT_W'(fire);
        end
    end

    // Addresses need no reset: a cleared mask makes stale entries unreachable
    always_ff @(posedge clock) begin
        for (int k = 0; k < NUM_THREADS; k++)
            if (hs) addr_q[k] <= bus.trace_read_address[DATA_WIDTH*k +: DATA_WIDTH];
    end
endmodule

// File: tb/tb_memtrace_lane_issuer.sv
// tb_memtrace_lane_issuer: directed and random stimulus against a queue-based behavioural model
module tb_memtrace_lane_issuer;
    localparam int N = 4, MI = 2, CW = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic done, error;
    logic [CW-1:0] req_count;

    memtrace_lane_issuer_if #(.NUM_THREADS(N)) bus ();
    memtrace_lane_issuer #(.NUM_THREADS(N), .MAX_INFLIGHT(MI), .CNT_W(CW)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus),
        .done(done),
        .error(error),
        .req_count(req_count)
    );

    always #5 clock = ~clock;

    typedef struct { int tid; logic [63:0] addr; } lane_t;
    lane_t q[$];
    int m_out = 0;
    bit m_fin = 0, m_drain = 0, m_done = 0, m_err = 0;
    int unsigned m_cnt = 0;
    int checks = 0, fails = 0, cyc = 0, hs_cyc = 0;
    int log_tid[$], log_cyc[$];
    logic [63:0] log_addr[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [63:0] a0, a1, a2, a3);
        bus.trace_read_address = {a3, a2, a1, a0};
        bus.trace_read_valid = 1'b1;
        tick();
        bus.trace_read_valid = 1'b0;
    endtask

    task automatic wait_quiet();
        int k;
        bus.req_ready = 1'b1;
        for (k = 0; k < 60; k++) begin
            bus.resp_valid = m_out > 0;
            if (q.size() == 0 && m_out == 0) break;
            tick();
        end
        bus.resp_valid = 1'b0;
        if (k == 60) begin
            fails++;
            $display("FAIL quiet_timeout at cycle %0d: outstanding %0d pending %0d", cyc, m_out, q.size());
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Model state here describes the cycle after the coming edge; inputs are stable until then
    always @(negedge clock) begin
        bit exp_rdy, exp_rv, hs, fire, fin, was_drain;
        int out_new;
        logic [63:0] a;
        exp_rdy = !reset && q.size() == 0 && !m_drain && !m_done;
        exp_rv  = !reset && q.size() > 0 && m_out < MI;
        check("ready", bus.trace_read_ready, exp_rdy);
        check("req_valid", bus.req_valid, exp_rv);
        check("req_addr", bus.req_addr, exp_rv ? q[0].addr : 64'd0);
        check("req_tid", bus.req_tid, exp_rv ? q[0].tid : 0);
        check("done", done, !reset && m_done);
        if (reset) begin
            q.delete();
            m_out = 0; m_fin = 0; m_drain = 0; m_done = 0; m_err = 0; m_cnt = 0;
        end else begin
            check("error", error, m_err);
            check("req_count", req_count, m_cnt);
            if (bus.req_valid && bus.req_ready) begin
                log_tid.push_back(int'(bus.req_tid));
                log_addr.push_back(bus.req_addr);
                log_cyc.push_back(cyc);
            end
            was_drain = m_drain;
            hs   = exp_rdy && bus.trace_read_valid;
            fire = exp_rv && bus.req_ready;
            fin  = m_fin || bus.trace_read_finished;
            if (hs) begin
                hs_cyc = cyc;
                for (int g = 0; g < N; g++) begin
                    a = bus.trace_read_address[64*g +: 64];
                    if (a != 0) q.push_back('{g, a});
                end
                if (q.size() == 0 && fin) m_drain = 1;
            end else if (exp_rdy && fin) m_drain = 1;
            if (fire) begin
                void'(q.pop_front());
                m_cnt++;
                if (q.size() == 0 && fin) m_drain = 1;
            end
            if (bus.resp_valid && m_out == 0) m_err = 1;
            out_new = m_out + int'(fire) - int'(bus.resp_valid && m_out > 0);
            if (was_drain && out_new == 0) m_done = 1;
            m_out = out_new;
            m_fin = fin;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int lb, nr;
        bus.trace_read_valid = 0; bus.trace_read_address = '0; bus.trace_read_finished = 0;
        bus.req_ready = 1; bus.resp_valid = 0;
        tick(); tick();
        reset = 0;
        tick();
        check("rst_ready", bus.trace_read_ready, 1);
        check("rst_req_valid", bus.req_valid, 0);
        check("rst_count", req_count, 0);
        check("rst_error", error, 0);

        // Full bundle: one lane per cycle, ready returns after the last
        lb = log_tid.size();
        send(64'h100, 64'h200, 64'h300, 64'h400);
        for (int k = 0; k < 4; k++) begin
            bus.resp_valid = m_out > 0;
            tick();
        end
        check("t1_ready_back", bus.trace_read_ready, 1);
        check("t1_count", req_count, 4);
        check("t1_nfires", log_tid.size() - lb, 4);
        for (int k = 0; k < 4; k++) begin
            check("t1_tid", log_tid[lb+k], k);
            check("t1_addr", log_addr[lb+k], 64'h100 * (k + 1));
            check("t1_cyc", log_cyc[lb+k], hs_cyc + 1 + k);
        end
        wait_quiet();

        // Sparse bundle, then all-zero bundle
        lb = log_tid.size();
        send(64'h0, 64'hA0, 64'h0, 64'hC0);
        for (int k = 0; k < 3; k++) begin
            bus.resp_valid = m_out > 0;
            tick();
        end
        check("t2_nfires", log_tid.size() - lb, 2);
        check("t2_tid0", log_tid[lb], 1);
        check("t2_addr0", log_addr[lb], 64'hA0);
        check("t2_tid1", log_tid[lb+1], 3);
        check("t2_addr1", log_addr[lb+1], 64'hC0);
        wait_quiet();
        lb = log_tid.size();
        send(0, 0, 0, 0);
        tick(); tick();
        check("t2_zero_nofire", log_tid.size() - lb, 0);
        check("t2_zero_ready", bus.trace_read_ready, 1);

        // In-flight limit without responses
        lb = log_tid.size();
        bus.resp_valid = 0;
        send(64'h11, 64'h22, 64'h33, 64'h44);
        repeat (5) tick();
        check("t3_limit_fires", log_tid.size() - lb, 2);
        check("t3_limit_valid", bus.req_valid, 0);
        bus.resp_valid = 1; tick(); bus.resp_valid = 0;
        repeat (3) tick();
        check("t3_one_more", log_tid.size() - lb, 3);
        bus.resp_valid = 1; tick();
        check("t3_valid_after_resp", bus.req_valid, 1);
        tick(); bus.resp_valid = 0;
        check("t3_fire_resp", log_tid.size() - lb, 4);
        send(64'h55, 64'h66, 64'h0, 64'h0);
        repeat (4) tick();
        check("t3_out_kept", log_tid.size() - lb, 5);
        wait_quiet();

        // Stall: request held stable
        lb = log_tid.size();
        bus.req_ready = 0;
        send(64'h77, 64'h0, 64'h88, 64'h0);
        for (int k = 0; k < 5; k++) begin
            check("t4_hold_valid", bus.req_valid, 1);
            check("t4_hold_tid", bus.req_tid, 0);
            check("t4_hold_addr", bus.req_addr, 64'h77);
            tick();
        end
        wait_quiet();
        check("t4_nfires", log_tid.size() - lb, 2);
        check("t4_order", log_tid[lb+1], 2);
        check("t4_addr", log_addr[lb+1], 64'h88);

        // Random traffic checked by the model every cycle
        for (int k = 0; k < 400; k++) begin
            for (int g = 0; g < N; g++)
                bus.trace_read_address[64*g +: 64] = ($urandom % 3 == 0) ? 64'd0 : {$urandom, $urandom};
            bus.trace_read_valid = ($urandom % 3) == 0;
            bus.req_ready = ($urandom % 4) != 0;
            bus.resp_valid = m_out > 0 && ($urandom % 2) == 1;
            tick();
        end
        bus.trace_read_valid = 0;
        wait_quiet();

        // Valid and finished together: issue, drain, then done
        lb = log_tid.size();
        bus.trace_read_finished = 1;
        send(64'h1000, 64'h2000, 64'h3000, 64'h0);
        nr = 0;
        for (int k = 0; k < 20 && nr < 3; k++) begin
            bus.resp_valid = m_out > 0;
            if (bus.resp_valid) nr++;
            tick();
            if (nr < 3) check("t5_done_early", done, 0);
        end
        bus.resp_valid = 0;
        check("t5_nresp", nr, 3);
        check("t5_nfires", log_tid.size() - lb, 3);
        check("t5_last_tid", log_tid[lb+2], 2);
        for (int k = 0; k < 4; k++) begin
            check("t5_done", done, 1);
            check("t5_ready", bus.trace_read_ready, 0);
            tick();
        end

        // Response with nothing in flight
        bus.resp_valid = 1; tick(); bus.resp_valid = 0;
        for (int k = 0; k < 3; k++) begin
            check("t6_error", error, 1);
            tick();
        end

        // Reset in the middle of issuing
        reset = 1; tick(); reset = 0;
        bus.trace_read_finished = 0;
        tick();
        bus.req_ready = 1;
        send(64'h5, 64'h6, 64'h7, 64'h0);
        tick();
        bus.req_ready = 0;
        check("t7_mid_count", req_count, 1);
        check("t7_mid_valid", bus.req_valid, 1);
        reset = 1;
        #1;
        check("t7_rst_ready", bus.trace_read_ready, 0);
        check("t7_rst_valid", bus.req_valid, 0);
        tick();
        reset = 0;
        tick();
        check("t7_ready", bus.trace_read_ready, 1);
        check("t7_valid", bus.req_valid, 0);
        check("t7_count", req_count, 0);
        check("t7_error", error, 0);
        check("t7_done", done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
